// File: rtl/multicycle_controller.sv
// Multi-cycle control sequencer for an RV32I subset (R-type, lw, sw, beq) sharing one
// instruction/data memory through a req/ready handshake; retires one instruction per pass.
module multicycle_controller #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             reg_write,
  output logic             memtoreg,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             trap,
  output logic [CNT_W-1:0] instret
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_ALU_WB, S_MEM_ADDR,
    S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_TRAP
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [TW-1:0]    r_wcnt;
  logic [CNT_W-1:0] r_instret;
  logic             w_wait;
  logic             w_timeout;
  logic             w_retire;

  assign w_wait    = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
  // Timeout fires on the cycle the stalled count would reach MEM_TIMEOUT; ready wins.
  assign w_timeout = w_wait && !mem_ready && (r_wcnt == TW'(MEM_TIMEOUT - 1));
  assign w_retire  = (r_state == S_ALU_WB) || (r_state == S_MEM_WB) || (r_state == S_BRANCH) ||
                     ((r_state == S_MEM_WR) && mem_ready);
  assign instret   = r_instret;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_FETCH;
      r_wcnt    <= '0;
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      if (w_wait && !mem_ready) r_wcnt <= r_wcnt + TW'(1);
      else                      r_wcnt <= '0;
      if (w_retire) r_instret <= r_instret + CNT_W'(1);
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:    if (mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          5'b01100:          w_next = S_EXEC_R;
          5'b00000, 5'b01000: w_next = S_MEM_ADDR;
          5'b11000:          w_next = S_BRANCH;
          default:           w_next = S_TRAP;
        endcase
      end
      S_EXEC_R:   w_next = S_ALU_WB;
      S_ALU_WB:   w_next = S_FETCH;
      S_MEM_ADDR: w_next = (opcode == 5'b00000) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem_ready) w_next = S_MEM_WB;
      S_MEM_WB:   w_next = S_FETCH;
      S_MEM_WR:   if (mem_ready) w_next = S_FETCH;
      S_BRANCH:   w_next = S_FETCH;
      S_TRAP:     w_next = S_TRAP;
      default:    w_next = S_TRAP;
    endcase
    if (w_timeout) w_next = S_TRAP;
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    iord      = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 1'b0;
    reg_write = 1'b0;
    memtoreg  = 1'b0;
    alu_src   = 1'b0;
    alu_op    = 2'b00;
    trap      = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_req  = 1'b1;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      S_EXEC_R: alu_op = 2'b10;
      S_ALU_WB: begin
        reg_write = 1'b1;
        alu_op    = 2'b10;
      end
      S_MEM_ADDR: alu_src = 1'b1;
      S_MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        alu_src = 1'b1;
      end
      S_MEM_WB: begin
        reg_write = 1'b1;
        memtoreg  = 1'b1;
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        alu_src = 1'b1;
      end
      S_BRANCH: begin
        alu_op   = 2'b01;
        pc_src   = 1'b1;
        pc_write = zero;
      end
      S_TRAP:  trap = 1'b1;
      default: ;
    endcase
    // Reset must silence the memory port immediately, even mid-access.
    if (!rst) begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      iord      = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      pc_src    = 1'b0;
      reg_write = 1'b0;
      memtoreg  = 1'b0;
      alu_src   = 1'b0;
      alu_op    = 2'b00;
      trap      = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-instruction expected waveforms built from the
// instruction's phase list, checked on a 32-bit and a 4-bit-counter build in lockstep.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] opcode;
  logic       zero;
  logic       mem_ready;

  always #5 clk = ~clk;

  logic        a_req, a_we, a_iord, a_irw, a_pcw, a_pcs, a_rw, a_m2r, a_asrc, a_trap;
  logic [1:0]  a_op;
  logic [31:0] a_instret;
  logic        b_req, b_we, b_iord, b_irw, b_pcw, b_pcs, b_rw, b_m2r, b_asrc, b_trap;
  logic [1:0]  b_op;
  logic [3:0]  b_instret;

  multicycle_controller #(.CNT_W(32), .MEM_TIMEOUT(16)) u_dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(a_req), .mem_we(a_we), .iord(a_iord), .ir_write(a_irw), .pc_write(a_pcw),
    .pc_src(a_pcs), .reg_write(a_rw), .memtoreg(a_m2r), .alu_src(a_asrc), .alu_op(a_op),
    .trap(a_trap), .instret(a_instret)
  );

  multicycle_controller #(.CNT_W(4), .MEM_TIMEOUT(16)) u_dut4 (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(b_req), .mem_we(b_we), .iord(b_iord), .ir_write(b_irw), .pc_write(b_pcw),
    .pc_src(b_pcs), .reg_write(b_rw), .memtoreg(b_m2r), .alu_src(b_asrc), .alu_op(b_op),
    .trap(b_trap), .instret(b_instret)
  );

  logic [11:0] outs_a, outs_b;
  assign outs_a = {a_req, a_we, a_iord, a_irw, a_pcw, a_pcs, a_rw, a_m2r, a_asrc, a_op, a_trap};
  assign outs_b = {b_req, b_we, b_iord, b_irw, b_pcw, b_pcs, b_rw, b_m2r, b_asrc, b_op, b_trap};

  localparam logic [11:0] O_REQ  = 12'h800, O_WE  = 12'h400, O_IORD = 12'h200;
  localparam logic [11:0] O_IRW  = 12'h100, O_PCW = 12'h080, O_PCS  = 12'h040;
  localparam logic [11:0] O_RW   = 12'h020, O_M2R = 12'h010, O_ASRC = 12'h008;
  localparam logic [11:0] O_OPF  = 12'h004, O_OPS = 12'h002, O_TRAP = 12'h001;
  localparam logic [4:0]  OP_R = 5'b01100, OP_LW = 5'b00000, OP_SW = 5'b01000, OP_BEQ = 5'b11000;

  typedef struct { logic rdy; logic [11:0] o; } cyc_t;
  typedef struct { logic [4:0] op; logic z; int df; int dm; int rw; int pcw; } vec_t;

  cyc_t        q[$];
  vec_t        tbl[8];
  int          nchk = 0;
  int          nfail = 0;
  int unsigned m_instret = 0;
  int          rw_seen, pcw_seen;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_cnt(input string name);
    chk(name, 64'(a_instret), 64'(m_instret));
    chk({name, "_w4"}, 64'(b_instret), 64'(m_instret % 16));
  endtask

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic rdy, input logic [11:0] o);
    cyc_t c;
    c.rdy = rdy;
    c.o   = o;
    q.push_back(c);
  endtask

  // Expected cycle-by-cycle outputs of one instruction, with df/dm stalled cycles
  // in the fetch and data accesses; ready is random wherever no request is pending.
  task automatic build(input logic [4:0] op, input logic z, input int df, input int dm);
    for (int i = 0; i < df; i++) push(1'b0, O_REQ);
    push(1'b1, O_REQ | O_IRW | O_PCW);
    push(rnd(), 12'h000);
    case (op)
      OP_R: begin
        push(rnd(), O_OPF);
        push(rnd(), O_RW | O_OPF);
      end
      OP_LW: begin
        push(rnd(), O_ASRC);
        for (int i = 0; i < dm; i++) push(1'b0, O_REQ | O_IORD | O_ASRC);
        push(1'b1, O_REQ | O_IORD | O_ASRC);
        push(rnd(), O_RW | O_M2R);
      end
      OP_SW: begin
        push(rnd(), O_ASRC);
        for (int i = 0; i < dm; i++) push(1'b0, O_REQ | O_WE | O_IORD | O_ASRC);
        push(1'b1, O_REQ | O_WE | O_IORD | O_ASRC);
      end
      OP_BEQ: push(rnd(), O_OPS | O_PCS | (z ? O_PCW : 12'h000));
      default: ;
    endcase
  endtask

  task automatic play(input string name);
    cyc_t c;
    rw_seen  = 0;
    pcw_seen = 0;
    while (q.size() > 0) begin
      c = q.pop_front();
      mem_ready = c.rdy;
      @(negedge clk);
      chk(name, 64'({outs_a, outs_b}), 64'({c.o, c.o}));
      rw_seen  += int'(a_rw);
      pcw_seen += int'(a_pcw);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst       = 1'b0;
    mem_ready = 1'b1;
    m_instret = 0;
    @(negedge clk);
    chk("reset_outs", 64'({outs_a, outs_b}), 64'(0));
    chk_cnt("reset_instret");
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    logic [4:0] ops [4];
    ops[0] = OP_R; ops[1] = OP_LW; ops[2] = OP_SW; ops[3] = OP_BEQ;
    tbl[0] = '{OP_R,   1'b0, 0,  0,  1, 1};
    tbl[1] = '{OP_LW,  1'b0, 0,  3,  1, 1};
    tbl[2] = '{OP_SW,  1'b0, 2,  1,  0, 1};
    tbl[3] = '{OP_BEQ, 1'b1, 0,  0,  0, 2};
    tbl[4] = '{OP_BEQ, 1'b0, 1,  0,  0, 1};
    tbl[5] = '{OP_R,   1'b1, 4,  0,  1, 1};
    tbl[6] = '{OP_LW,  1'b0, 15, 15, 1, 1};
    tbl[7] = '{OP_SW,  1'b0, 0,  15, 0, 1};

    rst = 1'b0; opcode = OP_R; zero = 1'b0; mem_ready = 1'b0;
    do_reset();

    for (int i = 0; i < 8; i++) begin
      opcode = tbl[i].op;
      zero   = tbl[i].z;
      build(tbl[i].op, tbl[i].z, tbl[i].df, tbl[i].dm);
      play($sformatf("vec%0d_wave", i));
      chk($sformatf("vec%0d_regwrite", i), 64'(rw_seen), 64'(tbl[i].rw));
      chk($sformatf("vec%0d_pcwrite", i), 64'(pcw_seen), 64'(tbl[i].pcw));
      m_instret++;
      chk_cnt($sformatf("vec%0d_instret", i));
    end

    // Illegal opcode: trap is absorbing and nothing retires.
    opcode = 5'b11111;
    push(1'b1, O_REQ | O_IRW | O_PCW);
    push(rnd(), 12'h000);
    for (int i = 0; i < 6; i++) push(rnd(), O_TRAP);
    play("illegal_trap");
    chk_cnt("illegal_instret");
    do_reset();

    // Store stalled for the full timeout window traps without retiring.
    opcode = OP_SW;
    push(1'b1, O_REQ | O_IRW | O_PCW);
    push(rnd(), 12'h000);
    push(rnd(), O_ASRC);
    for (int i = 0; i < 16; i++) push(1'b0, O_REQ | O_WE | O_IORD | O_ASRC);
    for (int i = 0; i < 4; i++) push(rnd(), O_TRAP);
    play("sw_timeout");
    chk_cnt("sw_timeout_instret");
    do_reset();

    // Reset asserted in the middle of a store wait.
    opcode = OP_R;
    build(OP_R, 1'b0, 0, 0);
    play("pre_reset_r");
    m_instret++;
    chk_cnt("pre_reset_instret");
    opcode = OP_SW;
    build(OP_SW, 1'b0, 0, 0);
    void'(q.pop_back());
    for (int i = 0; i < 3; i++) push(1'b0, O_REQ | O_WE | O_IORD | O_ASRC);
    play("sw_wait");
    mem_ready = 1'b0;
    #2;
    rst = 1'b0;
    m_instret = 0;
    #1;
    chk("midreset_outs", 64'({outs_a, outs_b}), 64'(0));
    chk_cnt("midreset_instret");
    @(posedge clk);
    #1;
    rst = 1'b1;
    opcode = OP_R;
    build(OP_R, 1'b0, 0, 0);
    play("restart_r");
    m_instret++;
    chk_cnt("restart_instret");

    // Sixteen retirements wrap the 4-bit counter back to zero.
    do_reset();
    opcode = OP_BEQ;
    for (int i = 0; i < 16; i++) begin
      zero = rnd();
      build(OP_BEQ, zero, 0, 0);
      play("beq_run");
      m_instret++;
      chk_cnt("beq_run_instret");
    end
    chk("wrap_w4", 64'(b_instret), 64'(0));

    // Random instruction mix with short random stalls.
    for (int n = 0; n < 60; n++) begin
      logic [4:0] op;
      logic       z;
      op = ops[$urandom_range(0, 3)];
      z  = rnd();
      opcode = op;
      zero   = z;
      build(op, z, int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
      play("rand_wave");
      m_instret++;
      chk_cnt("rand_instret");
    end

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
